// File: rtl/vending_machine_def.sv
// ---------------------------------------------------------------------------
// vending_machine_def
// Shared definitions for the change dispenser:
//   kTotalBits  - width of change amounts and of the remaining-amount register
//   kNumCoins   - number of coin denominations (one-hot coin_sel width)
//   kCoinValue  - coin values, index 0 = 100, 1 = 500, 2 = 1000
//   state_t     - dispenser FSM state encoding (2 bits)
// ---------------------------------------------------------------------------
package vending_machine_def;

    localparam int kTotalBits = 16;
    localparam int kNumCoins  = 3;

    localparam logic [kTotalBits-1:0] kCoinValue [kNumCoins] = '{16'd100, 16'd500, 16'd1000};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_DONE     = 2'd2
    } state_t;

endpackage

// File: rtl/coin_select.sv
// ---------------------------------------------------------------------------
// coin_select
// Combinational greedy picker: selects the largest available denomination
// whose value does not exceed the remaining amount.
// Ports:
//   remain   in   amount still to be paid out
//   avail    in   per-denomination availability mask (bit i = kCoinValue[i])
//   coin_sel out  one-hot selected denomination, all-zero when none fits
//   found    out  high when a denomination was selected
// ---------------------------------------------------------------------------
module coin_select
    import vending_machine_def::*;
(
    input  logic [kTotalBits-1:0] remain,
    input  logic [kNumCoins-1:0]  avail,
    output logic [kNumCoins-1:0]  coin_sel,
    output logic                  found
);

    // Scan from the highest index (largest coin) down; first fit wins.
    always_comb begin
        coin_sel = '0;
        found    = 1'b0;
        for (int i = kNumCoins - 1; i >= 0; i--) begin
            if (!found && avail[i] && (remain >= kCoinValue[i])) begin
                coin_sel[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
// Accepts a change amount and pays it out greedily (1000, 500, 100) as a
// sequence of coin handshakes to a hopper, then pulses done.
//
// Optional feature macro: COIN_INVENTORY_EN
//   defined   - per-denomination coin counters, refill input, shortfall and
//               residue outputs; an empty denomination is skipped.
//   undefined - unlimited supply; any residue below 100 is dropped at DONE.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   return_valid/ready       change-amount handshake (accepted only in IDLE)
//   return_total             change amount
//   coin_valid/ready         coin handshake with the hopper
//   coin_sel                 one-hot denomination, zero when coin_valid is low
//   done                     one-cycle completion pulse
//   busy                     high in DISPENSE and DONE
//   refill                   (inventory) reload all counters, honoured in IDLE
//   shortfall                (inventory) high with done when change is missing
//   residue                  (inventory) unpaid amount while done, else 0
//   state, remain            debug view of the FSM state and remaining amount
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, and coin_sel is held while valid waits.
// ---------------------------------------------------------------------------
module change_dispenser
    import vending_machine_def::*;
#(
    parameter int kInitInventory = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  return_valid,
    input  logic [kTotalBits-1:0] return_total,
    output logic                  return_ready,
    output logic                  coin_valid,
    output logic [kNumCoins-1:0]  coin_sel,
    input  logic                  coin_ready,
    output logic                  done,
    output logic                  busy,
`ifdef COIN_INVENTORY_EN
    input  logic                  refill,
    output logic                  shortfall,
    output logic [kTotalBits-1:0] residue,
`endif
    output logic [1:0]            state,
    output logic [kTotalBits-1:0] remain
);

    state_t                  state_q, state_d;
    logic [kTotalBits-1:0]   remain_q, remain_d;
    logic [kNumCoins-1:0]    avail;
    logic [kNumCoins-1:0]    pick;
    logic                    found;
    logic [kTotalBits-1:0]   coin_val;

    coin_select u_coin_select (
        .remain   (remain_q),
        .avail    (avail),
        .coin_sel (pick),
        .found    (found)
    );

`ifdef COIN_INVENTORY_EN
    localparam int kCntBits = $clog2(kInitInventory + 1);

    logic [kCntBits-1:0] cnt_q [kNumCoins];

    always_comb begin
        avail = '0;
        for (int i = 0; i < kNumCoins; i++) begin
            avail[i] = (cnt_q[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < kNumCoins; i++) begin
                cnt_q[i] <= kCntBits'(kInitInventory);
            end
        end else if (state_q == ST_IDLE && refill) begin
            for (int i = 0; i < kNumCoins; i++) begin
                cnt_q[i] <= kCntBits'(kInitInventory);
            end
        end else if (coin_valid && coin_ready) begin
            for (int i = 0; i < kNumCoins; i++) begin
                if (coin_sel[i]) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                end
            end
        end
    end

    assign shortfall = done && (remain_q != '0);
    assign residue   = done ? remain_q : '0;
`else
    assign avail = '1;
`endif

    // Value of the denomination currently picked.
    always_comb begin
        coin_val = '0;
        for (int i = 0; i < kNumCoins; i++) begin
            if (pick[i]) begin
                coin_val = kCoinValue[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        remain_d     = remain_q;
        return_ready = 1'b0;
        coin_valid   = 1'b0;
        coin_sel     = '0;
        done         = 1'b0;
        busy         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                return_ready = 1'b1;
                if (return_valid) begin
                    remain_d = return_total;
                    state_d  = (return_total != '0) ? ST_DISPENSE : ST_DONE;
                end
            end
            ST_DISPENSE: begin
                busy = 1'b1;
                if (found) begin
                    coin_valid = 1'b1;
                    coin_sel   = pick;
                    if (coin_ready) begin
                        // coin_val <= remain_q by construction, so no underflow.
                        remain_d = remain_q - coin_val;
                        if (remain_q == coin_val) begin
                            state_d = ST_DONE;
                        end
                    end
                end else begin
                    // Nothing fits: keep the residue in remain for DONE to report.
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                remain_d = '0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                remain_d = '0;
            end
        endcase
    end

    assign state  = state_q;
    assign remain = remain_q;

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter kInitInventory, default 8, SHALL set the per-denomination coin count loaded at reset and on refill.
REQ-002 clk  input  1  SHALL be the single system clock; all state updates occur on its rising edge.
REQ-003 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 return_valid  input  1  SHALL indicate that a change amount is offered.
REQ-005 return_total  input  kTotalBits  SHALL carry the change amount to dispense.
REQ-006 return_ready  output  1  SHALL indicate that the block accepts a new amount; it is high only in IDLE.
REQ-007 coin_valid  output  1  SHALL indicate that a coin is presented to the hopper.
REQ-008 coin_sel  output  kNumCoins  SHALL give the one-hot coin denomination presented; it is all-zero when coin_valid is low.
REQ-009 coin_ready  input  1  SHALL indicate that the hopper consumed the presented coin.
REQ-010 done  output  1  SHALL pulse high for one cycle when a dispense completes.
REQ-011 busy  output  1  SHALL be high in DISPENSE and DONE.

Function
REQ-012 The FSM SHALL have states IDLE, DISPENSE and DONE, encoded in 2 bits.
REQ-013 In IDLE, a cycle with return_valid=1 and return_total≠0 SHALL latch remain=return_total and move to DISPENSE on the same edge.
REQ-014 In IDLE, return_valid=1 with return_total=0 SHALL move to DONE without presenting any coin.
REQ-015 In DISPENSE, coin_sel SHALL select the largest available denomination with value ≤ remain, and coin_valid SHALL be 1, combinationally from the registered state.
REQ-016 Greedy order SHALL be 1000, 500, 100.
REQ-017 A coin handshake completes on a cycle with coin_valid&&coin_ready=1; on that edge, remain SHALL decrease by the coin value.
REQ-018 Exactly one coin SHALL transfer per completed handshake, with at most one per cycle.
REQ-019 coin_sel SHALL stay stable while coin_valid=1 and coin_ready=0.
REQ-020 When the remain after the handshake equals 0, the FSM SHALL move to DONE.
REQ-021 When remain>0 and no denomination qualifies, DISPENSE SHALL move to DONE with coin_valid=0 on that cycle.
REQ-022 In that no-coin case, the residue SHALL be held in remain.
REQ-023 DONE SHALL assert done for one cycle and then return to IDLE.
REQ-024 return_valid SHALL be ignored outside IDLE.
REQ-025 Latency: an accept at edge N SHALL present the first coin_valid in cycle N+1, and done SHALL rise the cycle after the last handshake.
REQ-026 remain SHALL be kTotalBits wide and SHALL never underflow.

Reset
REQ-027 reset_n=0 SHALL immediately force IDLE, remain=0 and coin_valid=0.
REQ-028 Reset SHALL also force coin_sel=0, done=0 and busy=0, and set return_ready=1 once released.
REQ-029 Reset SHALL set all inventory counters to kInitInventory.
REQ-030 Reset during DISPENSE SHALL abandon the transaction with no done pulse.

Configuration
REQ-031 With COIN_INVENTORY_EN defined, the block SHALL keep per-denomination counters of $clog2(kInitInventory+1) bits.
REQ-032 With COIN_INVENTORY_EN defined, each handshake SHALL decrement the counter of the denomination dispensed.
REQ-033 With COIN_INVENTORY_EN defined, a denomination whose count is 0 SHALL be unavailable.
REQ-034 With COIN_INVENTORY_EN defined, the block SHALL add input refill (1 bit), which reloads all counters to kInitInventory when pulsed in IDLE.
REQ-035 With COIN_INVENTORY_EN defined, the block SHALL add output shortfall (1 bit), high together with done when remain≠0.
REQ-036 With COIN_INVENTORY_EN defined, the block SHALL add output residue (kTotalBits), equal to remain while done is high and 0 otherwise.
REQ-037 Without COIN_INVENTORY_EN, supply SHALL be unlimited, and refill, shortfall and residue SHALL be absent.
REQ-038 Without COIN_INVENTORY_EN, a non-multiple-of-100 residue SHALL be silently dropped at DONE.

Structure
REQ-039 The shared vending_machine_def package SHALL hold kTotalBits, kNumCoins=3, the coin values array {100,500,1000}, and the FSM state encodings.
REQ-040 Greedy selection SHALL be a combinational sub-module, coin_select, whose inputs are remain and the availability mask and whose outputs are a one-hot coin_sel and a found flag.

Verification
REQ-041 A bench SHALL drive return_total=1600 with coin_ready=1 and check coin_sel sequence 1000, 500, 100 on three consecutive cycles, then done in the next cycle, then return to IDLE.
REQ-042 A bench SHALL drive return_total=500 with coin_ready=0 for 4 cycles and check that coin_valid=1 and coin_sel=500 hold stable, with exactly one coin after coin_ready=1.
REQ-043 A bench SHALL drive return_valid with return_total=0 and check no coin_valid, done one cycle later, and busy=1 for that cycle.
REQ-044 A bench SHALL drive return_total=1100, assert reset_n=0 after the first handshake, and check immediate IDLE, remain=0, no done, and return_ready=1.
REQ-045 A bench SHALL, with COIN_INVENTORY_EN defined and the 1000 count at 0, drive return_total=1000 and check two 500 coins, shortfall=0, and the 500 count at 6.
REQ-046 A bench SHALL, with COIN_INVENTORY_EN defined, drive return_total=150 and check one 100 coin, then done with shortfall=1 and residue=50.
